// File: rtl/game_pkg.sv
// Shared types and round-length tables for the whack-a-mole round controller.
package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_PLAY,
      ST_OVER,
      ST_PAUSED
   } state_e;

   typedef logic [3:0] bcd_t;

   // Round length in seconds per difficulty level: 60 / 45 / 30 / 15.
   localparam bcd_t ROUND_TENS [4] = '{4'd6, 4'd4, 4'd3, 4'd1};
   localparam bcd_t ROUND_ONES [4] = '{4'd0, 4'd5, 4'd0, 4'd5};

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score counter: synchronous clear, increment, saturates at 99.
module bcd_score_counter
   import game_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic inc_i,
   output bcd_t tens_o,
   output bcd_t ones_o
);

   bcd_t tens_q, tens_d;
   bcd_t ones_q, ones_d;
   logic at_max;

   assign at_max = (tens_q == 4'd9) && (ones_q == 4'd9);

   always_comb begin
      tens_d = tens_q;
      ones_d = ones_q;
      if (clr_i) begin
         tens_d = 4'd0;
         ones_d = 4'd0;
      end else if (inc_i && !at_max) begin
         if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tens_q <= 4'd0;
         ones_q <= 4'd0;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end

   assign tens_o = tens_q;
   assign ones_o = ones_q;

endmodule

// File: rtl/game_sequencer.sv
// Whack-a-mole round controller: timer loading, round end, BCD score, mole tick.
// Optional pause support is enabled by defining GAME_PAUSE_EN.
module game_sequencer
   import game_pkg::*;
#(
   parameter int MOLE_PERIOD = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       pause,
   input  logic [1:0] level,
   input  logic       hit,
   input  logic [3:0] tmr_tens,
   input  logic [3:0] tmr_ones,
   output logic       tmr_load,
   output logic [3:0] tmr_load_tens,
   output logic [3:0] tmr_load_ones,
   output logic       mole_tick,
   output logic [3:0] score_tens,
   output logic [3:0] score_ones,
   output logic       playing,
   output logic       game_over
);

   localparam int CW = $clog2(MOLE_PERIOD + 1);

   state_e        state_q, state_d;
   logic [1:0]    level_q, level_d;
   logic [CW-1:0] mole_cnt_q, mole_cnt_d, mole_last;
   logic [31:0]   mole_period;
   logic          mole_tick_q, mole_tick_d;
   logic          playing_q, game_over_q;
   logic          tmr_zero, score_clr, score_inc;

`ifdef GAME_PAUSE_EN
   bcd_t hold_tens_q, hold_tens_d;
   bcd_t hold_ones_q, hold_ones_d;
`else
   logic unused_pause;
   assign unused_pause = pause;
`endif

   assign tmr_zero    = (tmr_tens == 4'd0) && (tmr_ones == 4'd0);
   // Short periods at high levels can shift to zero; treat that as a tick every cycle.
   assign mole_period = 32'(MOLE_PERIOD) >> level_q;
   assign mole_last   = (mole_period == 32'd0) ? '0 : CW'(mole_period - 32'd1);

   always_comb begin
      state_d       = state_q;
      level_d       = level_q;
      mole_cnt_d    = mole_cnt_q;
      mole_tick_d   = 1'b0;
      score_clr     = 1'b0;
      score_inc     = 1'b0;
      tmr_load      = 1'b0;
      tmr_load_tens = ROUND_TENS[level_q];
      tmr_load_ones = ROUND_ONES[level_q];
`ifdef GAME_PAUSE_EN
      hold_tens_d   = hold_tens_q;
      hold_ones_d   = hold_ones_q;
`endif
      case (state_q)
         ST_IDLE: begin
            tmr_load      = 1'b1;
            tmr_load_tens = ROUND_TENS[level];
            tmr_load_ones = ROUND_ONES[level];
            if (start) begin
               state_d = ST_ARM;
               level_d = level;
            end
         end
         ST_ARM: begin
            tmr_load   = 1'b1;
            score_clr  = 1'b1;
            mole_cnt_d = '0;
            state_d    = ST_PLAY;
         end
         ST_PLAY: begin
            score_inc = hit;
            if (mole_cnt_q >= mole_last) begin
               mole_cnt_d  = '0;
               mole_tick_d = 1'b1;
            end else begin
               mole_cnt_d = mole_cnt_q + CW'(1);
            end
            // Round end takes priority over a simultaneous pause request.
            if (tmr_zero) begin
               state_d = ST_OVER;
`ifdef GAME_PAUSE_EN
            end else if (pause) begin
               state_d     = ST_PAUSED;
               hold_tens_d = tmr_tens;
               hold_ones_d = tmr_ones;
`endif
            end
         end
         ST_OVER: begin
            if (start) begin
               state_d = ST_ARM;
               level_d = level;
            end
         end
`ifdef GAME_PAUSE_EN
         ST_PAUSED: begin
            tmr_load      = 1'b1;
            tmr_load_tens = hold_tens_q;
            tmr_load_ones = hold_ones_q;
            if (pause) begin
               state_d = ST_PLAY;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         level_q     <= 2'd0;
         mole_cnt_q  <= '0;
         mole_tick_q <= 1'b0;
         playing_q   <= 1'b0;
         game_over_q <= 1'b0;
`ifdef GAME_PAUSE_EN
         hold_tens_q <= 4'd0;
         hold_ones_q <= 4'd0;
`endif
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         mole_cnt_q  <= mole_cnt_d;
         mole_tick_q <= mole_tick_d;
         playing_q   <= (state_d == ST_PLAY);
         game_over_q <= (state_d == ST_OVER);
`ifdef GAME_PAUSE_EN
         hold_tens_q <= hold_tens_d;
         hold_ones_q <= hold_ones_d;
`endif
      end
   end

   bcd_score_counter u_score (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (score_clr),
      .inc_i  (score_inc),
      .tens_o (score_tens),
      .ones_o (score_ones)
   );

   assign mole_tick = mole_tick_q;
   assign playing   = playing_q;
   assign game_over = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer with a behavioural countdown timer (4 cycles/s).
module tb_game_sequencer;

   localparam int MP = 8;
`ifdef GAME_PAUSE_EN
   localparam bit PAUSE_EN = 1'b1;
`else
   localparam bit PAUSE_EN = 1'b0;
`endif
   localparam int PH_IDLE = 0, PH_ARM = 1, PH_PLAY = 2, PH_OVER = 3, PH_PAUSED = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, pause = 1'b0, hit = 1'b0;
   logic [1:0] level = 2'd2;
   logic [3:0] tmr_tens, tmr_ones;
   logic       tmr_load, mole_tick, playing, game_over;
   logic [3:0] tmr_load_tens, tmr_load_ones, score_tens, score_ones;

   int checks = 0;
   int errors = 0;

   int ROUND_S [4] = '{60, 45, 30, 15};
   int m_phase = PH_IDLE;
   int m_level = 0;
   int m_score = 0;
   int m_play  = 0;
   logic       m_tick = 1'b0;
   logic [7:0] m_cap = 8'h00;

   always #5 clk = ~clk;

   game_sequencer #(.MOLE_PERIOD(MP)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .pause         (pause),
      .level         (level),
      .hit           (hit),
      .tmr_tens      (tmr_tens),
      .tmr_ones      (tmr_ones),
      .tmr_load      (tmr_load),
      .tmr_load_tens (tmr_load_tens),
      .tmr_load_ones (tmr_load_ones),
      .mole_tick     (mole_tick),
      .score_tens    (score_tens),
      .score_ones    (score_ones),
      .playing       (playing),
      .game_over     (game_over)
   );

   // Behavioural countdown timer: load restarts the sub-second count; stops at 00.
   logic [3:0] t_tens = 4'd0, t_ones = 4'd0;
   logic [1:0] t_sub  = 2'd0;
   assign tmr_tens = t_tens;
   assign tmr_ones = t_ones;

   always @(posedge clk) begin
      if (tmr_load) begin
         t_tens <= tmr_load_tens;
         t_ones <= tmr_load_ones;
         t_sub  <= 2'd0;
      end else if (!(t_tens == 4'd0 && t_ones == 4'd0)) begin
         if (t_sub == 2'd3) begin
            t_sub <= 2'd0;
            if (t_ones == 4'd0) begin
               t_ones <= 4'd9;
               t_tens <= t_tens - 4'd1;
            end else begin
               t_ones <= t_ones - 4'd1;
            end
         end else begin
            t_sub <= t_sub + 2'd1;
         end
      end
   end

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_outputs(input logic [1:0] lv);
      logic       exp_load;
      logic [7:0] exp_digits;
      exp_load   = 1'b0;
      exp_digits = 8'h00;
      if (m_phase == PH_IDLE) begin
         exp_load = 1'b1; exp_digits = to_bcd(ROUND_S[lv]);
      end else if (m_phase == PH_ARM) begin
         exp_load = 1'b1; exp_digits = to_bcd(ROUND_S[m_level]);
      end else if (m_phase == PH_PAUSED) begin
         exp_load = 1'b1; exp_digits = m_cap;
      end
      chk("playing",   32'(playing),   32'(m_phase == PH_PLAY));
      chk("game_over", 32'(game_over), 32'(m_phase == PH_OVER));
      chk("score",     32'({score_tens, score_ones}), 32'(to_bcd(m_score)));
      chk("mole_tick", 32'(mole_tick), 32'(m_tick));
      chk("tmr_load",  32'(tmr_load),  32'(exp_load));
      if (exp_load)
         chk("load_digits", 32'({tmr_load_tens, tmr_load_ones}), 32'(exp_digits));
   endtask

   // One clock cycle: apply inputs, advance the reference model, then check after the edge.
   task automatic cycle(input logic st, input logic ps, input logic ht, input logic [1:0] lv);
      logic zero;
      int   p;
      start = st; pause = ps; hit = ht; level = lv;
      zero   = (tmr_tens == 4'd0) && (tmr_ones == 4'd0);
      m_tick = 1'b0;
      case (m_phase)
         PH_IDLE, PH_OVER: if (st) begin m_phase = PH_ARM; m_level = int'(lv); end
         PH_ARM: begin m_phase = PH_PLAY; m_score = 0; m_play = 0; end
         PH_PLAY: begin
            if (ht && m_score < 99) m_score++;
            p = MP >> m_level;
            if (p < 1) p = 1;
            m_play++;
            if (m_play % p == 0) m_tick = 1'b1;
            if (zero) m_phase = PH_OVER;
            else if (ps && PAUSE_EN) begin m_phase = PH_PAUSED; m_cap = {tmr_tens, tmr_ones}; end
         end
         PH_PAUSED: if (ps) m_phase = PH_PLAY;
         default: m_phase = PH_IDLE;
      endcase
      @(posedge clk); #1;
      check_outputs(lv);
      start = 1'b0; pause = 1'b0; hit = 1'b0;
   endtask

   // Random play (hits, stray start/pause, level wiggle) until the round ends.
   task automatic run_to_over(input int hit_pct, input int bound);
      logic zero, ht, ps, st;
      logic [1:0] lv;
      for (int i = 0; i < bound && m_phase != PH_OVER; i++) begin
         zero = (tmr_tens == 4'd0) && (tmr_ones == 4'd0);
         ht   = zero ? 1'b1 : ($urandom_range(0, 99) < hit_pct);
         ps   = zero ? 1'b1 : ($urandom_range(0, 31) == 0);
         st   = ($urandom_range(0, 15) == 0);
         lv   = 2'($urandom_range(0, 3));
         cycle(st, ps, ht, lv);
      end
      chk("reach_over", 32'(game_over), 32'd1);
      $display("round level=%0d over score=%0h%0h", m_level, score_tens, score_ones);
   endtask

   initial begin
      // Reset with level 2: IDLE, loading 30.
      level = 2'd2;
      #23;
      check_outputs(2'd2);
      @(posedge clk); #1;
      rst_n = 1'b1;
      $display("reset released");

      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 2'd2);

      // Round 1: level 2 (30 s, tick every 2 cycles).
      cycle(1'b1, 1'b0, 1'b0, 2'd2);
      cycle(1'b0, 1'b0, 1'b0, 2'd3);
      run_to_over(30, 2000);

      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 2'd1);

      // Round 2: level 0 (60 s), hit every cycle to reach saturation.
      cycle(1'b1, 1'b0, 1'b0, 2'd0);
      cycle(1'b0, 1'b0, 1'b1, 2'd0);
      run_to_over(100, 3000);
      chk("saturated", 32'({score_tens, score_ones}), 32'h99);

`ifdef GAME_PAUSE_EN
      // Pause at 27: timer frozen for 50 cycles, then resumes.
      cycle(1'b1, 1'b0, 1'b0, 2'd2);
      cycle(1'b0, 1'b0, 1'b0, 2'd2);
      for (int i = 0; i < 400 && {tmr_tens, tmr_ones} != 8'h27; i++)
         cycle(1'b0, 1'b0, 1'b0, 2'd2);
      cycle(1'b0, 1'b1, 1'b0, 2'd2);
      for (int i = 0; i < 50; i++) begin
         cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 2'd2);
         chk("paused_digits", 32'({tmr_tens, tmr_ones}), 32'h27);
      end
      cycle(1'b0, 1'b1, 1'b0, 2'd2);
      chk("resume_digits", 32'({tmr_tens, tmr_ones}), 32'h27);
      run_to_over(20, 2000);
`endif

      // Round 3: level 1, then asynchronous reset mid-round.
      cycle(1'b1, 1'b0, 1'b0, 2'd1);
      cycle(1'b0, 1'b0, 1'b0, 2'd1);
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 2'd1);
      level = 2'd3;
      #2;
      rst_n = 1'b0;
      #1;
      m_phase = PH_IDLE; m_score = 0; m_tick = 1'b0;
      check_outputs(2'd3);
      $display("reset asserted mid-round");
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1, 2'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
